// File: rtl/gpu_pkg.sv
// Shared frame-buffer layout and column-writer state encoding, used by both the
// column writer and the display read side.
package gpu_pkg;

    localparam int          COLUMNS_DEFAULT = 320;
    localparam int          COL_W           = 9;
    localparam int          WORD_W          = 16;

    localparam logic [15:0] DIST_A_BASE     = 16'd63488;
    localparam logic [15:0] TEX_A_BASE      = 16'd63808;
    localparam logic [15:0] DIST_B_BASE     = 16'd64128;
    localparam logic [15:0] TEX_B_BASE      = 16'd64448;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_DIST   = 2'd1,
        WR_TEX    = 2'd2,
        WAIT_SWAP = 2'd3
    } wr_state_t;

    // Writes always go to the buffer that is not on screen.
    function automatic logic [15:0] back_base(input logic        front_sel,
                                              input logic [15:0] base_a,
                                              input logic [15:0] base_b);
        return front_sel ? base_a : base_b;
    endfunction

    function automatic logic column_in_range(input logic [COL_W-1:0] column,
                                             input int               columns);
        return int'(column) < columns;
    endfunction

endpackage

// File: rtl/falling_edge_detect.sv
// One-cycle pulse on a high-to-low transition of a same-domain level signal.
module falling_edge_detect (
    input  logic clk,
    input  logic clr,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Resets high so a signal that is already low after reset is not seen as an edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in_q & ~in;

endmodule

// File: rtl/column_buffer_writer.sv
// Writes per-column distance/texture words into the back frame buffer and swaps
// front/back on the first v_sync falling edge after a frame's last column.
module column_buffer_writer
    import gpu_pkg::*;
#(
    parameter int          COLUMNS = COLUMNS_DEFAULT,
    parameter logic [15:0] DIST_A  = DIST_A_BASE,
    parameter logic [15:0] TEX_A   = TEX_A_BASE,
    parameter logic [15:0] DIST_B  = DIST_B_BASE,
    parameter logic [15:0] TEX_B   = TEX_B_BASE
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_column,
    input  logic [15:0] in_distance,
    input  logic [15:0] in_texture,
    input  logic        in_last,
    input  logic        v_sync,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_grant,
    output logic        buffer_select,
    output logic        swap_pending,
    output logic        range_error
);

    wr_state_t   state_q, state_d;
    logic [8:0]  column_q, column_d;
    logic [15:0] distance_q, distance_d;
    logic [15:0] texture_q, texture_d;
    logic        last_q, last_d;
    logic        select_q, select_d;
    logic        range_err_q, range_err_d;

    logic        v_sync_fall;
    logic [15:0] col_offset;
    logic [15:0] dist_back;
    logic [15:0] tex_back;

    falling_edge_detect u_vsync_edge (
        .clk   (clk),
        .clr   (clr),
        .in    (v_sync),
        .pulse (v_sync_fall)
    );

    assign col_offset = {7'd0, column_q};
    assign dist_back  = back_base(select_q, DIST_A, DIST_B);
    assign tex_back   = back_base(select_q, TEX_A, TEX_B);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            column_q    <= '0;
            distance_q  <= '0;
            texture_q   <= '0;
            last_q      <= 1'b0;
            select_q    <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            column_q    <= column_d;
            distance_q  <= distance_d;
            texture_q   <= texture_d;
            last_q      <= last_d;
            select_q    <= select_d;
            range_err_q <= range_err_d;
        end
    end

    // Memory outputs are decoded from state, so an asynchronous clear drops
    // mem_we and zeroes the address/data bus immediately.
    always_comb begin
        state_d      = state_q;
        column_d     = column_q;
        distance_d   = distance_q;
        texture_d    = texture_q;
        last_d       = last_q;
        select_d     = select_q;
        range_err_d  = range_err_q;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        swap_pending = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    column_d   = in_column;
                    distance_d = in_distance;
                    texture_d  = in_texture;
                    last_d     = in_last;
                    if (column_in_range(in_column, COLUMNS)) begin
                        state_d = WR_DIST;
                    end else begin
                        // Out-of-range entries are dropped but still close the frame.
                        range_err_d = 1'b1;
                        state_d     = in_last ? WAIT_SWAP : IDLE;
                    end
                end
            end

            WR_DIST: begin
                mem_we    = 1'b1;
                mem_addr  = dist_back + col_offset;
                mem_wdata = distance_q;
                if (mem_grant) begin
                    state_d = WR_TEX;
                end
            end

            WR_TEX: begin
                mem_we    = 1'b1;
                mem_addr  = tex_back + col_offset;
                mem_wdata = texture_q;
                if (mem_grant) begin
                    state_d = last_q ? WAIT_SWAP : IDLE;
                end
            end

            WAIT_SWAP: begin
                swap_pending = 1'b1;
                if (v_sync_fall) begin
                    select_d = ~select_q;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign buffer_select = select_q;
    assign range_error   = range_err_q;

endmodule

// File: tb/tb_column_buffer_writer.sv
// Directed bench for column_buffer_writer with a write-queue/buffer model checked every cycle.
module tb_column_buffer_writer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_column = '0;
    logic [15:0] in_distance = '0;
    logic [15:0] in_texture = '0;
    logic        in_last = 1'b0;
    logic        v_sync = 1'b1;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_grant = 1'b1;
    logic        buffer_select;
    logic        swap_pending;
    logic        range_error;

    column_buffer_writer dut (
        .clk           (clk),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_column     (in_column),
        .in_distance   (in_distance),
        .in_texture    (in_texture),
        .in_last       (in_last),
        .v_sync        (v_sync),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_grant     (mem_grant),
        .buffer_select (buffer_select),
        .swap_pending  (swap_pending),
        .range_error   (range_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endfunction

    // Model: queue of writes still owed, which buffer is on screen, whether a frame waits for v_sync.
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          fin;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    logic        m_sel, m_pending, m_rerr, vs_prev;
    logic        prev_we, prev_grant;
    logic [15:0] prev_addr, prev_data;

    initial begin
        wr_t  e;
        logic fe;
        forever begin
            @(negedge clk);
            if (!clr) begin
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_buffer_select", buffer_select, 0);
                chk("rst_swap_pending", swap_pending, 0);
                chk("rst_range_error", range_error, 0);
                exp_q.delete();
                m_sel = 0; m_pending = 0; m_rerr = 0; vs_prev = 1;
                prev_we = 0; prev_grant = 0; prev_addr = 0; prev_data = 0;
            end else begin
                chk("buffer_select", buffer_select, m_sel);
                chk("swap_pending", swap_pending, m_pending);
                chk("range_error", range_error, m_rerr);
                chk("in_ready", in_ready, (exp_q.size() == 0 && !m_pending));
                if (prev_we && !prev_grant) begin
                    chk("hold_we", mem_we, 1);
                    chk("hold_addr", mem_addr, prev_addr);
                    chk("hold_data", mem_wdata, prev_data);
                end
                if (mem_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        chk("write_addr", mem_addr, exp_q[0].addr);
                        chk("write_data", mem_wdata, exp_q[0].data);
                    end
                end
                // Advance the model across the coming clock edge.
                fe = vs_prev && !v_sync;
                if (m_pending && fe) begin
                    m_sel     = ~m_sel;
                    m_pending = 0;
                end
                if (mem_we && mem_grant) begin
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                    $display("write addr=%0d data=%h sel=%0d", mem_addr, mem_wdata, buffer_select);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        if (e.fin) m_pending = 1;
                    end
                end
                if (in_valid && in_ready) begin
                    if (in_column >= 9'd320) begin
                        m_rerr = 1;
                        if (in_last) m_pending = 1;
                    end else begin
                        e.addr = (m_sel ? 16'd63488 : 16'd64128) + {7'd0, in_column};
                        e.data = in_distance;
                        e.fin  = 0;
                        exp_q.push_back(e);
                        e.addr = (m_sel ? 16'd63808 : 16'd64448) + {7'd0, in_column};
                        e.data = in_texture;
                        e.fin  = in_last;
                        exp_q.push_back(e);
                    end
                end
                prev_we    = mem_we;
                prev_grant = mem_grant;
                prev_addr  = mem_addr;
                prev_data  = mem_wdata;
                vs_prev    = v_sync;
            end
        end
    end

    // Offers one entry; returns 1 ns after the accepting clock edge.
    task automatic send(input logic [8:0] c, input logic [15:0] d, input logic [15:0] t, input logic l);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        in_valid = 1; in_column = c; in_distance = d; in_texture = t; in_last = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        chk("send_accepted", acc, 1);
        @(posedge clk); #1;
        in_valid = 0;
        $display("sent column=%0d dist=%h tex=%h last=%0d", c, d, t, l);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, dc, tc, wc;
        repeat (3) @(negedge clk);
        #2 clr = 1;

        // Single in-range column, grant always high.
        n = log_addr.size();
        send(9'd5, 16'h1234, 16'h00AB, 0);
        @(negedge clk); chk("t1_ready_c1", in_ready, 0);
        @(negedge clk); chk("t1_ready_c2", in_ready, 0);
        @(negedge clk); chk("t1_ready_c3", in_ready, 1);
        chk("t1_nwrites", log_addr.size() - n, 2);
        chk("t1_addr0", log_addr[n], 16'd64133);
        chk("t1_data0", log_data[n], 16'h1234);
        chk("t1_addr1", log_addr[n+1], 16'd64453);
        chk("t1_data1", log_data[n+1], 16'h00AB);

        // Grant withheld for four cycles of the distance write.
        mem_grant = 0;
        n = log_addr.size();
        send(9'd9, 16'hBEEF, 16'h5A5A, 0);
        dc = 0; tc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 16'd64137) dc++;
            if (mem_we && mem_addr == 16'd64457) tc++;
            if (i == 3) begin
                @(posedge clk); #1 mem_grant = 1;
            end
        end
        chk("t2_dist_cycles", dc, 5);
        chk("t2_tex_cycles", tc, 1);
        chk("t2_nwrites", log_addr.size() - n, 2);
        chk("t2_data0", log_data[n], 16'hBEEF);

        // Last column of frame, then swap on v_sync falling edge.
        n = log_addr.size();
        send(9'd319, 16'h0319, 16'h1319, 1);
        repeat (4) @(negedge clk);
        chk("t3_pending", swap_pending, 1);
        chk("t3_sel_before", buffer_select, 0);
        chk("t3_ready_blocked", in_ready, 0);
        chk("t3_addr0", log_addr[n], 16'd64447);
        chk("t3_addr1", log_addr[n+1], 16'd64767);
        @(posedge clk); #1 v_sync = 0;
        @(negedge clk); chk("t3_pending_at_edge", swap_pending, 1);
        @(posedge clk); #1 v_sync = 1;
        @(negedge clk);
        chk("t3_sel_after", buffer_select, 1);
        chk("t3_pending_after", swap_pending, 0);
        n = log_addr.size();
        send(9'd0, 16'h0A0A, 16'h0B0B, 0);
        repeat (3) @(negedge clk);
        chk("t3_a_dist", log_addr[n], 16'd63488);
        chk("t3_a_tex", log_addr[n+1], 16'd63808);

        // Out-of-range column: no writes, sticky error across a frame swap.
        n = log_addr.size();
        send(9'd400, 16'hDEAD, 16'hDEAD, 0);
        wc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_we) wc++;
            if (i == 0) begin
                chk("t4_range_error", range_error, 1);
                chk("t4_ready_next", in_ready, 1);
            end
        end
        chk("t4_no_we", wc, 0);
        chk("t4_no_writes", log_addr.size() - n, 0);
        n = log_addr.size();
        send(9'd10, 16'h0001, 16'h0002, 1);
        repeat (4) @(negedge clk);
        chk("t4_a_dist", log_addr[n], 16'd63498);
        chk("t4_a_tex", log_addr[n+1], 16'd63818);
        @(posedge clk); #1 v_sync = 0;
        @(posedge clk); #1 v_sync = 1;
        @(negedge clk);
        chk("t4_sel_back", buffer_select, 0);
        chk("t4_error_sticky", range_error, 1);

        // Edge in IDLE is ignored; edge during final texture write is not remembered.
        @(posedge clk); #1 v_sync = 0;
        repeat (2) @(posedge clk);
        #1 v_sync = 1;
        @(negedge clk);
        chk("t5_idle_edge_sel", buffer_select, 0);
        chk("t5_idle_edge_pend", swap_pending, 0);
        send(9'd20, 16'h0003, 16'h0004, 1);
        @(posedge clk); #1 v_sync = 0;
        repeat (4) @(negedge clk);
        chk("t5_coincide_pend", swap_pending, 1);
        chk("t5_coincide_sel", buffer_select, 0);
        @(posedge clk); #1 v_sync = 1;
        @(posedge clk); #1 v_sync = 0;
        @(negedge clk); chk("t5_pend_at_edge", swap_pending, 1);
        @(posedge clk); #1 v_sync = 1;
        @(negedge clk);
        chk("t5_sel_after", buffer_select, 1);
        chk("t5_pend_after", swap_pending, 0);

        // Asynchronous clear in the middle of the texture write.
        send(9'd7, 16'h0005, 16'h0006, 0);
        @(posedge clk); #1;
        chk("t6_pre_we", mem_we, 1);
        clr = 0;
        #1;
        chk("t6_we_async", mem_we, 0);
        chk("t6_addr_async", mem_addr, 0);
        chk("t6_sel_async", buffer_select, 0);
        chk("t6_error_async", range_error, 0);
        @(negedge clk); #2 clr = 1;
        @(posedge clk); #1;
        chk("t6_ready_after", in_ready, 1);
        chk("t6_sel_after", buffer_select, 0);

        n = log_addr.size();
        send(9'd1, 16'h0007, 16'h0008, 0);
        repeat (4) @(negedge clk);
        chk("t7_dist_addr", log_addr[n], 16'd64129);
        chk("t7_tex_addr", log_addr[n+1], 16'd64449);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
